// File: rtl/nn_mem_pkg.sv
// Shared constants and state encoding for the NN on-chip RAM access blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nn_mem_pkg;

    localparam int ADDR_W = 17;  // 128 KiB byte-addressed RAM
    localparam int DATA_W = 8;   // RAM and stream byte width
    localparam int LEN_W  = 18;  // transfer length, 0..131072

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/nn_mem_stream_reader_if.sv
// Command, RAM port-s2 and byte-stream signals of the RAM stream reader.
// Latency: none (wiring only).
// Backpressure: st_ready from the sink, cmd_ready towards the command source.
interface nn_mem_stream_reader_if;
    import nn_mem_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_last;

    // Reader side
    modport master (
        input  cmd_valid, cmd_base, cmd_len,
        output cmd_ready,
        output mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
        input  mem_readdata,
        output st_data, st_valid, st_last,
        input  st_ready
    );

    // Command source, RAM and stream sink side
    modport slave (
        output cmd_valid, cmd_base, cmd_len,
        input  cmd_ready,
        input  mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata,
        output mem_readdata,
        input  st_data, st_valid, st_last,
        output st_ready
    );

endinterface

// File: rtl/nn_byte_fifo.sv
// Small synchronous FIFO holding a byte plus its last tag, with occupancy count.
// Latency: a pushed entry is visible at dout the cycle after the push.
// Backpressure: none internally; the writer must respect count (push while full only with a pop).
module nn_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A push into a full FIFO is only taken when a pop frees the slot that cycle.
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/nn_mem_stream_reader.sv
// Reads a (base, len) byte range from RAM port s2 and streams it out in address order.
// Latency: first byte valid 2 cycles after command accept; N bytes finish with done at accept+N+2.
// Backpressure: st_ready stalls the stream; reads pause once FIFO entries plus the in-flight read fill the FIFO.
module nn_mem_stream_reader
    import nn_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    nn_mem_stream_reader_if.master bus,
    output logic                   busy,
    output logic                   done
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              inflight_q;
    logic              tag_q;      // the in-flight read is the final one of the command
    logic              done_q;

    logic              accept;
    logic              issue;
    logic              pop;
    logic              last_pop;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W:0]   fifo_dout;
    logic [CW:0]       used;

    // Credits consumed: bytes buffered plus the read whose data arrives next cycle.
    assign used     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign accept   = (state_q == IDLE) && bus.cmd_valid;
    assign pop      = !fifo_empty && bus.st_ready;
    assign last_pop = pop && fifo_dout[DATA_W];

    // Next-state and read-issue decision.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && (bus.cmd_len != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                issue = (rem_q != '0) && (used < DEPTH_C);
                if (issue && (rem_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address/length counters, in-flight tracking and the completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                addr_q <= bus.cmd_base;
                rem_q  <= bus.cmd_len;
                if (bus.cmd_len == '0) begin
                    done_q <= 1'b1;
                end
            end
            if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);  // wraps 0x1FFFF -> 0x00000
                rem_q  <= rem_q - LEN_W'(1);
                tag_q  <= (rem_q == LEN_W'(1));
            end
            // RAM answers every read exactly one cycle later, so the flag follows issue.
            inflight_q <= issue;
            if ((state_q == DRAIN) && last_pop) begin
                done_q <= 1'b1;
            end
        end
    end

    nn_byte_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .din   ({tag_q, bus.mem_readdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.cmd_ready      = (state_q == IDLE);
    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_clken      = 1'b1;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_writedata  = '0;
    assign bus.st_valid       = !fifo_empty;
    assign bus.st_data        = fifo_dout[DATA_W-1:0];
    assign bus.st_last        = !fifo_empty && fifo_dout[DATA_W];
    assign busy               = (state_q != IDLE);
    assign done               = done_q;

endmodule
